// File: rtl/decode_loop_checker.sv
// Self-test sequencer for a 3-to-8 decoder feeding an 8-to-3 encoder:
// sweeps every select code, then checks the disabled state, and reports a verdict.
module decode_loop_checker #(
    parameter int NUM_PASSES = 1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic [2:0] code_in,
    output logic [2:0] sel,
    output logic       dec_en_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [2:0] first_err_sel
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DIS,
        DONE
    } state_e;

    localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - 1);

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic [7:0] err_q, err_d;
    logic [2:0] first_q, first_d;
    logic       pass_q, pass_d;

    logic       en_b;
    logic [2:0] exp_code;
    logic       mism;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            pcnt_q  <= 4'd0;
            err_q   <= 8'd0;
            first_q <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    // Disabled pair returns all ones; enabled pair returns the inverted select.
    always_comb begin
        en_b     = (state_q != RUN);
        exp_code = en_b ? 3'b111 : ~sel_q;
        mism     = ((state_q == RUN) || (state_q == DIS)) && (code_in != exp_code);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;

        // err_q stays nonzero once set, so zero marks the first mismatch.
        if (mism) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (err_q == 8'd0) begin
                first_d = sel_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (start) begin
                    state_d = RUN;
                    pcnt_d  = 4'd0;
                    err_d   = 8'd0;
                    first_d = 3'd0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                sel_d = sel_q + 3'd1;
                if (sel_q == 3'd7) begin
                    pcnt_d = pcnt_q + 4'd1;
                    if (pcnt_q == LAST_PASS) begin
                        state_d = DIS;
                        pcnt_d  = 4'd0;
                    end
                end
            end
            DIS: begin
                state_d = DONE;
                sel_d   = 3'd0;
                pass_d  = (err_d == 8'd0);
            end
            DONE: begin
                state_d = IDLE;
                sel_d   = 3'd0;
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
            end
        endcase
    end

    assign sel           = sel_q;
    assign dec_en_b      = en_b;
    assign busy          = (state_q == RUN) || (state_q == DIS);
    assign done          = (state_q == DONE);
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err_sel = first_q;

endmodule
